thunderbird_ctrl: RTL and testbench

THUNDERBIRD_CTRL -- requirements
Module: thunderbird_ctrl

---
 rtl/thunderbird_pkg.sv | 47 ++++
 rtl/thunderbird_sync.sv | 28 ++
 rtl/thunderbird_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_thunderbird_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/thunderbird_pkg.sv
// thunderbird_pkg -- shared types and constants for the thunderbird tail-lamp
// controller.
//   state_e          : controller state (IDLE, LEFT, RIGHT, HAZARD)
//   PAT_*            : 3-bit lamp patterns, bit order {C,B,A}
//   TICK_DIV_DEFAULT : default clk cycles per lamp step
//   pat_for_phase()  : turn-signal pattern for a given phase
//   arbitrate()      : request priority (hazard / both sides > left > right)
package thunderbird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } state_e;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_1   = 3'b001;
  localparam logic [2:0] PAT_2   = 3'b011;
  localparam logic [2:0] PAT_3   = 3'b111;

  localparam int unsigned TICK_DIV_DEFAULT = 12500000;

  // Turn sequence: phase 1,2,3 light progressively more lamps, phase 0 is dark.
  function automatic logic [2:0] pat_for_phase(input logic [1:0] phase);
    logic [2:0] pat;
    case (phase)
      2'd1:    pat = PAT_1;
      2'd2:    pat = PAT_2;
      2'd3:    pat = PAT_3;
      default: pat = PAT_OFF;
    endcase
    return pat;
  endfunction

  // Both turn sides together are treated as a hazard request.
  function automatic state_e arbitrate(input logic left, input logic right,
                                       input logic hazard);
    state_e win;
    if (hazard || (left && right)) win = ST_HAZARD;
    else if (left)                 win = ST_LEFT;
    else if (right)                win = ST_RIGHT;
    else                           win = ST_IDLE;
    return win;
  endfunction

endpackage

// File: rtl/thunderbird_sync.sv
// thunderbird_sync -- two-flop synchronizer for one asynchronous level input.
//   clk : sampling clock
//   rst : asynchronous active-low reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
module thunderbird_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/thunderbird_ctrl.sv
// thunderbird_ctrl -- Ford Thunderbird style sequential tail-lamp controller.
//   Parameter TICK_DIV : clk cycles per lamp step (2 .. 2**24)
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   left     : left turn request (asynchronous level)
//   right    : right turn request (asynchronous level)
//   hazard   : hazard request (asynchronous level)
//   brake    : brake request (asynchronous level), only with THUNDERBIRD_BRAKE_EN
//   lamp_l   : registered left lamps {LC,LB,LA}
//   lamp_r   : registered right lamps {RC,RB,RA}
//   busy     : high whenever a sequence is running
//   seq_done : one-cycle pulse after each completed sequence
// Optional feature: define THUNDERBIRD_BRAKE_EN to add the brake input.
module thunderbird_ctrl
  import thunderbird_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
`ifdef THUNDERBIRD_BRAKE_EN
  input  logic       brake,
`endif
  output logic [2:0] lamp_l,
  output logic [2:0] lamp_r,
  output logic       busy,
  output logic       seq_done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic left_s;
  logic right_s;
  logic hazard_s;

  thunderbird_sync u_sync_left (
    .clk (clk),
    .rst (rst),
    .d   (left),
    .q   (left_s)
  );

  thunderbird_sync u_sync_right (
    .clk (clk),
    .rst (rst),
    .d   (right),
    .q   (right_s)
  );

  thunderbird_sync u_sync_hazard (
    .clk (clk),
    .rst (rst),
    .d   (hazard),
    .q   (hazard_s)
  );

`ifdef THUNDERBIRD_BRAKE_EN
  logic brake_s;

  thunderbird_sync u_sync_brake (
    .clk (clk),
    .rst (rst),
    .d   (brake),
    .q   (brake_s)
  );
`endif

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lamp_l_q, lamp_l_d;
  logic [2:0]       lamp_r_q, lamp_r_d;
  logic             seq_done_q, seq_done_d;

  logic             tick;
  state_e           win;

  assign tick = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
  assign win  = arbitrate(left_s, right_s, hazard_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      lamp_l_q   <= PAT_OFF;
      lamp_r_q   <= PAT_OFF;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      lamp_l_q   <= lamp_l_d;
      lamp_r_q   <= lamp_r_d;
      seq_done_q <= seq_done_d;
    end
  end

  // Next state, phase, step counter and end-of-sequence pulse.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    seq_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        phase_d = 2'd0;
        if (win != ST_IDLE) begin
          state_d = win;
          phase_d = 2'd1;
        end
      end

      ST_LEFT, ST_RIGHT: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          if (hazard_s) begin
            // Hazard cuts a turn sequence short; that is not a completion.
            state_d = ST_HAZARD;
            phase_d = 2'd1;
          end else if (phase_q == 2'd0) begin
            seq_done_d = 1'b1;
            state_d    = win;
            phase_d    = (win == ST_IDLE) ? 2'd0 : 2'd1;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end

      ST_HAZARD: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          if (phase_q == 2'd0) begin
            seq_done_d = 1'b1;
            state_d    = win;
            phase_d    = (win == ST_IDLE) ? 2'd0 : 2'd1;
          end else begin
            phase_d = 2'd0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge
  // as the state they belong to.
  always_comb begin
    lamp_l_d = PAT_OFF;
    lamp_r_d = PAT_OFF;

    case (state_d)
      ST_LEFT:   lamp_l_d = pat_for_phase(phase_d);
      ST_RIGHT:  lamp_r_d = pat_for_phase(phase_d);
      ST_HAZARD: begin
        lamp_l_d = (phase_d == 2'd1) ? PAT_3 : PAT_OFF;
        lamp_r_d = (phase_d == 2'd1) ? PAT_3 : PAT_OFF;
      end
      default: begin
        lamp_l_d = PAT_OFF;
        lamp_r_d = PAT_OFF;
      end
    endcase

`ifdef THUNDERBIRD_BRAKE_EN
    // Brake lights every side not busy with a turn; hazard flashing wins.
    if (brake_s) begin
      if ((state_d == ST_IDLE) || (state_d == ST_RIGHT)) lamp_l_d = PAT_3;
      if ((state_d == ST_IDLE) || (state_d == ST_LEFT))  lamp_r_d = PAT_3;
    end
`endif
  end

  assign lamp_l   = lamp_l_q;
  assign lamp_r   = lamp_r_q;
  assign busy     = (state_q != ST_IDLE);
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_thunderbird_ctrl.sv
// tb_thunderbird_ctrl -- directed self-checking bench for thunderbird_ctrl
// with TICK_DIV=4. Expected {lamp_l, lamp_r, busy, seq_done} values are queued
// against an absolute clock-edge number when stimulus is applied and compared
// on the falling edge after that rising edge.
module tb_thunderbird_ctrl;

  logic       clk;
  logic       rst;
  logic       left;
  logic       right;
  logic       hazard;
`ifdef THUNDERBIRD_BRAKE_EN
  logic       brake;
`endif
  logic [2:0] lamp_l;
  logic [2:0] lamp_r;
  logic       busy;
  logic       seq_done;

  thunderbird_ctrl #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .left     (left),
    .right    (right),
    .hazard   (hazard),
`ifdef THUNDERBIRD_BRAKE_EN
    .brake    (brake),
`endif
    .lamp_l   (lamp_l),
    .lamp_r   (lamp_r),
    .busy     (busy),
    .seq_done (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [7:0] obs_now();
    return {lamp_l, lamp_r, busy, seq_done};
  endfunction

  function automatic void exp_at(input int c, input logic [2:0] l,
                                 input logic [2:0] r, input logic b,
                                 input logic d, input string tag);
    exp_t e;
    e.cyc = c;
    e.exp = {l, r, b, d};
    e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed{l,r,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: rising edge, then compare every entry due at this edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, obs_now(), sb[i].exp);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        assert (sb[i].cyc >= cyc)
        else begin
          failures++;
          $error("FAIL %s missed due_edge=%0d now=%0d", sb[i].tag, sb[i].cyc, cyc);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    int t0;
    rst    = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
`ifdef THUNDERBIRD_BRAKE_EN
    brake  = 1'b0;
`endif
    #1;
    check("reset_state", obs_now(), 8'b000_000_0_0);
    step();
    step();
    rst = 1'b1;
    exp_at(cyc + 2, 3'b000, 3'b000, 1'b0, 1'b0, "idle_after_reset");
    drain(10);

    // Single-cycle left pulse: full left sequence, one seq_done, back to idle.
    t0 = cyc;
    left = 1'b1;
    exp_at(t0 + 2,  3'b000, 3'b000, 1'b0, 1'b0, "left_latency_e2");
    exp_at(t0 + 3,  3'b001, 3'b000, 1'b1, 1'b0, "left_p1");
    exp_at(t0 + 6,  3'b001, 3'b000, 1'b1, 1'b0, "left_p1_hold");
    exp_at(t0 + 7,  3'b011, 3'b000, 1'b1, 1'b0, "left_p2");
    exp_at(t0 + 11, 3'b111, 3'b000, 1'b1, 1'b0, "left_p3");
    exp_at(t0 + 15, 3'b000, 3'b000, 1'b1, 1'b0, "left_p0");
    exp_at(t0 + 18, 3'b000, 3'b000, 1'b1, 1'b0, "left_p0_hold");
    exp_at(t0 + 19, 3'b000, 3'b000, 1'b0, 1'b1, "left_done");
    exp_at(t0 + 20, 3'b000, 3'b000, 1'b0, 1'b0, "left_idle");
    step();
    left = 1'b0;
    drain(40);

    // Right held 40 cycles: back-to-back sequences, then completion to idle.
    t0 = cyc;
    right = 1'b1;
    exp_at(t0 + 3,  3'b000, 3'b001, 1'b1, 1'b0, "right_s1_p1");
    exp_at(t0 + 7,  3'b000, 3'b011, 1'b1, 1'b0, "right_s1_p2");
    exp_at(t0 + 19, 3'b000, 3'b001, 1'b1, 1'b1, "right_s2_reenter");
    exp_at(t0 + 20, 3'b000, 3'b001, 1'b1, 1'b0, "right_s2_pulse_end");
    exp_at(t0 + 23, 3'b000, 3'b011, 1'b1, 1'b0, "right_s2_p2");
    exp_at(t0 + 35, 3'b000, 3'b001, 1'b1, 1'b1, "right_s3_reenter");
    exp_at(t0 + 43, 3'b000, 3'b111, 1'b1, 1'b0, "right_s3_p3_after_release");
    exp_at(t0 + 47, 3'b000, 3'b000, 1'b1, 1'b0, "right_s3_p0");
    exp_at(t0 + 51, 3'b000, 3'b000, 1'b0, 1'b1, "right_final_done");
    exp_at(t0 + 52, 3'b000, 3'b000, 1'b0, 1'b0, "right_idle");
    repeat (40) step();
    right = 1'b0;
    drain(40);

    // Left and right together: hazard flashing, two full sequences.
    t0 = cyc;
    left  = 1'b1;
    right = 1'b1;
    exp_at(t0 + 3,  3'b111, 3'b111, 1'b1, 1'b0, "lr_haz_on");
    exp_at(t0 + 6,  3'b111, 3'b111, 1'b1, 1'b0, "lr_haz_on_hold");
    exp_at(t0 + 7,  3'b000, 3'b000, 1'b1, 1'b0, "lr_haz_off");
    exp_at(t0 + 11, 3'b111, 3'b111, 1'b1, 1'b1, "lr_haz_reenter");
    exp_at(t0 + 15, 3'b000, 3'b000, 1'b1, 1'b0, "lr_haz_off2");
    exp_at(t0 + 19, 3'b000, 3'b000, 1'b0, 1'b1, "lr_haz_done");
    repeat (10) step();
    left  = 1'b0;
    right = 1'b0;
    drain(30);

    // Hazard raised during LEFT phase 2: pre-empts at the next tick.
    t0 = cyc;
    left = 1'b1;
    exp_at(t0 + 7,  3'b011, 3'b000, 1'b1, 1'b0, "pre_left_p2");
    exp_at(t0 + 10, 3'b011, 3'b000, 1'b1, 1'b0, "pre_left_p2_hold");
    exp_at(t0 + 11, 3'b111, 3'b111, 1'b1, 1'b0, "pre_haz_no_done");
    exp_at(t0 + 15, 3'b000, 3'b000, 1'b1, 1'b0, "pre_haz_off");
    exp_at(t0 + 19, 3'b000, 3'b000, 1'b0, 1'b1, "pre_haz_done");
    step();
    left = 1'b0;
    repeat (6) step();
    hazard = 1'b1;
    step();
    step();
    hazard = 1'b0;
    drain(30);

    // Reset pulled low at LEFT phase 3: outputs clear before the next edge.
    t0 = cyc;
    left = 1'b1;
    exp_at(t0 + 11, 3'b111, 3'b000, 1'b1, 1'b0, "rst_left_p3");
    step();
    left = 1'b0;
    drain(20);
    step();
    rst = 1'b0;
    #1;
    check("rst_async_clear", obs_now(), 8'b000_000_0_0);
    exp_at(cyc + 1, 3'b000, 3'b000, 1'b0, 1'b0, "rst_held");
    step();
    step();
    rst = 1'b1;
    exp_at(cyc + 3, 3'b000, 3'b000, 1'b0, 1'b0, "rst_release_idle_e3");
    exp_at(cyc + 8, 3'b000, 3'b000, 1'b0, 1'b0, "rst_release_idle_e8");
    drain(20);

`ifdef THUNDERBIRD_BRAKE_EN
    // Brake with left held: right side lit; adding hazard overrides brake.
    t0 = cyc;
    left  = 1'b1;
    brake = 1'b1;
    exp_at(t0 + 3,  3'b001, 3'b111, 1'b1, 1'b0, "brake_left_p1");
    exp_at(t0 + 7,  3'b011, 3'b111, 1'b1, 1'b0, "brake_left_p2");
    exp_at(t0 + 11, 3'b111, 3'b111, 1'b1, 1'b0, "brake_haz_on");
    exp_at(t0 + 15, 3'b000, 3'b000, 1'b1, 1'b0, "brake_haz_off_ignored");
    exp_at(t0 + 19, 3'b000, 3'b000, 1'b0, 1'b1, "brake_haz_done");
    repeat (8) step();
    hazard = 1'b1;
    repeat (8) step();
    left   = 1'b0;
    hazard = 1'b0;
    brake  = 1'b0;
    drain(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
